// File: rtl/linalg_pkg.sv
// linalg_pkg: shared definitions for the linear-algebra blocks
// (mat_product, mat_serializer and later additions).
package linalg_pkg;

    // Native element width: one IEEE-754 single-precision word.
    localparam int WORD_W = 32;

    // Serializer control states.
    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } ser_state_t;

    // Width of an index counter that has to reach x-1; never narrower than one bit.
    function automatic int idx_w(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

endpackage

// File: rtl/mat_serializer.sv
// mat_serializer: accepts one packed MxN matrix per stb/ack handshake and
// streams its elements out one word per stb/ack handshake. Each word is tagged
// with its (row, col) position, and the final word of the matrix carries a
// last flag.
//
// Emission order is row-major by default. When MAT_SER_COL_MAJOR_EN is
// defined, the order is column-major. In both modes the indices report the
// element's true (row, col), and last marks (M-1, N-1).
//
// Handshake rule, used on both sides: a word moves on a rising edge where
// stb=1 and ack=1. The producer holds its data and stb until that edge. A
// consumer's ack is ignored while stb=0.
module mat_serializer
    import linalg_pkg::*;
#(
    parameter int M = 2,
    parameter int N = 2,
    parameter int W = WORD_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [M*N*W-1:0]      input_z,
    input  logic                  input_z_stb,
    output logic                  input_z_ack,
    output logic [W-1:0]          output_elem,
    output logic                  output_elem_stb,
    input  logic                  output_elem_ack,
    output logic                  output_last,
    output logic [idx_w(M)-1:0]   output_row,
    output logic [idx_w(N)-1:0]   output_col,
    output ser_state_t            state_dbg
);

    localparam int RW = idx_w(M);
    localparam int CW = idx_w(N);
    localparam int BW = $clog2(M*N*W);
    localparam logic [RW-1:0] ROW_MAX = RW'(M - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(N - 1);

    ser_state_t         state;
    logic [M*N*W-1:0]   mat_buf;
    logic [RW-1:0]      nxt_row;
    logic [CW-1:0]      nxt_col;
    logic               nxt_last;
    logic [BW-1:0]      nxt_base;
    logic [W-1:0]       nxt_elem;
    logic               in_xfer;
    logic               out_xfer;

    assign in_xfer   = (state == IDLE) && input_z_stb && input_z_ack;
    assign out_xfer  = (state == EMIT) && output_elem_stb && output_elem_ack;
    assign state_dbg = state;

    // Position of the element that follows the current one in emission order.
    always_comb begin
        nxt_row = output_row;
        nxt_col = output_col;
`ifdef MAT_SER_COL_MAJOR_EN
        if (output_row == ROW_MAX) begin
            nxt_row = '0;
            nxt_col = output_col + 1'b1;
        end else begin
            nxt_row = output_row + 1'b1;
        end
`else
        if (output_col == COL_MAX) begin
            nxt_col = '0;
            nxt_row = output_row + 1'b1;
        end else begin
            nxt_col = output_col + 1'b1;
        end
`endif
    end

    // Fetch the next word from the buffer and flag whether it is the final one.
    always_comb begin
        nxt_base = BW'((int'(nxt_row) * N + int'(nxt_col)) * W);
        nxt_elem = mat_buf[nxt_base +: W];
        nxt_last = (nxt_row == ROW_MAX) && (nxt_col == COL_MAX);
    end

    // Control FSM, matrix buffer and the registered output word/tags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            mat_buf         <= '0;
            input_z_ack     <= 1'b0;
            output_elem     <= '0;
            output_elem_stb <= 1'b0;
            output_last     <= 1'b0;
            output_row      <= '0;
            output_col      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_xfer) begin
                        // Element (0,0) sits in the low word; present it on the next edge.
                        mat_buf         <= input_z;
                        input_z_ack     <= 1'b0;
                        state           <= EMIT;
                        output_row      <= '0;
                        output_col      <= '0;
                        output_elem     <= input_z[W-1:0];
                        output_elem_stb <= 1'b1;
                        output_last     <= (M == 1) && (N == 1);
                    end else begin
                        input_z_ack <= 1'b1;
                    end
                end
                EMIT: begin
                    if (out_xfer) begin
                        if (output_last) begin
                            // Reopen the input on this same edge so the next matrix loses no cycle.
                            output_elem_stb <= 1'b0;
                            output_last     <= 1'b0;
                            output_row      <= '0;
                            output_col      <= '0;
                            input_z_ack     <= 1'b1;
                            state           <= IDLE;
                        end else begin
                            output_row  <= nxt_row;
                            output_col  <= nxt_col;
                            output_elem <= nxt_elem;
                            output_last <= nxt_last;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mat_serializer.sv
// tb_mat_serializer: randomized scoreboard bench for mat_serializer. Uses a
// 2x3 instance for the streaming tests and a 1x1 instance for the single-element
// case. The expected emission order comes from the (row, col) enumeration rule,
// including MAT_SER_COL_MAJOR_EN when that macro is defined.
`timescale 1ns/1ps
module tb_mat_serializer;
    import linalg_pkg::*;

    localparam int M  = 2;
    localparam int N  = 3;
    localparam int W  = 32;
    localparam int RW = idx_w(M);
    localparam int CW = idx_w(N);
    localparam int MW = M*N*W;
    localparam int EW = W + RW + CW + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- 2x3 DUT ----------------
    logic [MW-1:0]  input_z;
    logic           input_z_stb;
    logic           input_z_ack;
    logic [W-1:0]   output_elem;
    logic           output_elem_stb;
    logic           output_elem_ack;
    logic           output_last;
    logic [RW-1:0]  output_row;
    logic [CW-1:0]  output_col;
    ser_state_t     state_dbg;

    mat_serializer #(.M(M), .N(N), .W(W)) u_dut (
        .clk             (clk),
        .rst             (rst),
        .input_z         (input_z),
        .input_z_stb     (input_z_stb),
        .input_z_ack     (input_z_ack),
        .output_elem     (output_elem),
        .output_elem_stb (output_elem_stb),
        .output_elem_ack (output_elem_ack),
        .output_last     (output_last),
        .output_row      (output_row),
        .output_col      (output_col),
        .state_dbg       (state_dbg)
    );

    // ---------------- 1x1 DUT ----------------
    logic [W-1:0]   input_z1;
    logic           input_z_stb1;
    logic           input_z_ack1;
    logic [W-1:0]   output_elem1;
    logic           output_elem_stb1;
    logic           output_elem_ack1;
    logic           output_last1;
    logic [0:0]     output_row1;
    logic [0:0]     output_col1;
    ser_state_t     state_dbg1;

    mat_serializer #(.M(1), .N(1), .W(W)) u_dut1 (
        .clk             (clk),
        .rst             (rst),
        .input_z         (input_z1),
        .input_z_stb     (input_z_stb1),
        .input_z_ack     (input_z_ack1),
        .output_elem     (output_elem1),
        .output_elem_stb (output_elem_stb1),
        .output_elem_ack (output_elem_ack1),
        .output_last     (output_last1),
        .output_row      (output_row1),
        .output_col      (output_col1),
        .state_dbg       (state_dbg1)
    );

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [EW-1:0] exp_q[$];
    int ack_mode = 0;
    int out_xfers = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference model: enumerate the elements in emission order, tagging each with its true (row,col).
    task automatic push_expected(input logic [MW-1:0] m);
        for (int k = 0; k < M*N; k++) begin
            int r;
            int c;
            logic [W-1:0]  w;
            logic [RW-1:0] rr;
            logic [CW-1:0] cc;
            logic          lst;
`ifdef MAT_SER_COL_MAJOR_EN
            r = k % M;
            c = k / M;
`else
            r = k / N;
            c = k % N;
`endif
            w   = m[(r*N + c)*W +: W];
            rr  = RW'(r);
            cc  = CW'(c);
            lst = (r == M-1) && (c == N-1);
            exp_q.push_back({w, rr, cc, lst});
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_matrix(input logic [MW-1:0] m, input bit hold_after);
        int t;
        push_expected(m);
        input_z     = m;
        input_z_stb = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!input_z_ack && t < 200);
        if (!input_z_ack) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got no input_z_ack expected ack within 200 cycles");
        end
        @(posedge clk);
        #1;
        if (!hold_after) input_z_stb = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || output_elem_stb) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d words pending expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Downstream ack pattern: 0 = tied high, 1 = 1,0,0 repeating, 2 = random.
    initial begin
        int ph;
        ph = 0;
        output_elem_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ack_mode)
                0:       output_elem_ack = 1'b1;
                1:       output_elem_ack = (ph % 3 == 0);
                default: output_elem_ack = 1'($urandom_range(0, 1));
            endcase
            ph++;
        end
    end

    // ---------------- monitor ----------------
    logic [EW-1:0] held;
    bit held_v = 0;
    bit chk_after_last = 0;
    bit chk_after_acc = 0;
    bit chk_stay = 0;
    bit stb_waiting = 0;
    bit last_v = 0;
    int last_cyc = 0;

    always @(negedge clk) begin
        logic [EW-1:0] got;
        logic [EW-1:0] e;
        if (!rst) begin
            exp_q.delete();
            held_v = 0;
            chk_after_last = 0;
            chk_after_acc = 0;
            chk_stay = 0;
            stb_waiting = 0;
            last_v = 0;
        end else begin
            got = {output_elem, output_row, output_col, output_last};
            if (chk_after_last) begin
                check("ack_after_last", 64'(input_z_ack), 64'd1);
                check("stb_after_last", 64'(output_elem_stb), 64'd0);
                chk_after_last = 0;
            end
            if (chk_after_acc) begin
                check("first_valid_latency", 64'(output_elem_stb), 64'd1);
                chk_after_acc = 0;
            end
            if (chk_stay) begin
                check("stb_stays_high", 64'(output_elem_stb), 64'd1);
                chk_stay = 0;
            end
            if (held_v && output_elem_stb) check("held_stable", 64'(got), 64'(held));
            held_v = 0;
            if (output_elem_stb) begin
                if (output_elem_ack) begin
                    out_xfers++;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_elem: got %h expected no word", got);
                    end else begin
                        e = exp_q.pop_front();
                        check("elem", 64'(got), 64'(e));
                        if (e[0]) begin
                            chk_after_last = 1;
                            last_cyc = cyc;
                            last_v = 1;
                        end else begin
                            chk_stay = 1;
                        end
                    end
                end else begin
                    held_v = 1;
                    held = got;
                end
            end
            if (input_z_stb && input_z_ack) begin
                chk_after_acc = 1;
                if (stb_waiting && last_v) check("b2b_accept_gap", 64'(cyc - last_cyc), 64'd1);
                last_v = 0;
            end
            stb_waiting = input_z_stb && !input_z_ack;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [MW-1:0] m1;
        logic [MW-1:0] m2;
        logic [MW-1:0] mr;
        int base;
        int t;
        int prev;
        bit hold;

        input_z = '0;
        input_z_stb = 1'b0;
        input_z1 = '0;
        input_z_stb1 = 1'b0;
        output_elem_ack1 = 1'b0;
        m1 = {32'h40C00000, 32'h40A00000, 32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
        m2 = {32'h41400000, 32'h41300000, 32'h41200000, 32'h41100000, 32'h41000000, 32'h40E00000};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 64'(input_z_ack), 64'd0);
        check("rst_stb", 64'(output_elem_stb), 64'd0);
        check("rst_elem", 64'(output_elem), 64'd0);
        check("rst_last", 64'(output_last), 64'd0);
        check("rst_row", 64'(output_row), 64'd0);
        check("rst_col", 64'(output_col), 64'd0);
        check("rst_state", 64'(state_dbg), 64'(IDLE));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("ack_after_release", 64'(input_z_ack), 64'd1);

        // fixed matrix, ack tied high
        ack_mode = 0;
        send_matrix(m1, 0);
        wait_drain();

        // fixed matrix, ack 1,0,0 pattern
        ack_mode = 1;
        send_matrix(m1, 0);
        wait_drain();

        // back-to-back with stb held high
        ack_mode = 0;
        send_matrix(m1, 1);
        send_matrix(m2, 0);
        wait_drain();

        // randomized matrices, ack patterns and gaps
        for (int k = 0; k < 20; k++) begin
            ack_mode = $urandom_range(0, 2);
            for (int e = 0; e < M*N; e++) mr[e*W +: W] = $urandom;
            hold = (k < 19) ? 1'($urandom_range(0, 1)) : 1'b0;
            send_matrix(mr, hold);
            if (!hold) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
        end
        wait_drain();

        // asynchronous reset after the third element
        ack_mode = 0;
        base = out_xfers;
        send_matrix(m1, 0);
        t = 0;
        while (out_xfers < base + 3 && t < 100) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("arst_ack", 64'(input_z_ack), 64'd0);
        check("arst_stb", 64'(output_elem_stb), 64'd0);
        check("arst_elem", 64'(output_elem), 64'd0);
        check("arst_last", 64'(output_last), 64'd0);
        check("arst_row", 64'(output_row), 64'd0);
        check("arst_col", 64'(output_col), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("ack_after_rerelease", 64'(input_z_ack), 64'd1);
        for (int e = 0; e < M*N; e++) mr[e*W +: W] = $urandom;
        send_matrix(mr, 0);
        wait_drain();

        // 1x1 instance: three matrices with stb and ack held high
        input_z1 = 32'h41B00000;
        output_elem_ack1 = 1'b1;
        input_z_stb1 = 1'b1;
        prev = 0;
        for (int k = 0; k < 3; k++) begin
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!input_z_ack1 && t < 50);
            check("p1_accept", 64'(input_z_ack1), 64'd1);
            if (k > 0) check("p1_period", 64'(cyc - prev), 64'd2);
            prev = cyc;
            @(negedge clk);
            check("p1_stb", 64'(output_elem_stb1), 64'd1);
            check("p1_elem", 64'(output_elem1), 64'h41B00000);
            check("p1_last", 64'(output_last1), 64'd1);
            check("p1_row", 64'(output_row1), 64'd0);
            check("p1_col", 64'(output_col1), 64'd0);
            check("p1_ack_low", 64'(input_z_ack1), 64'd0);
            if (k == 2) input_z_stb1 = 1'b0;
        end
        @(negedge clk);
        check("p1_idle_stb", 64'(output_elem_stb1), 64'd0);
        check("p1_idle_ack", 64'(input_z_ack1), 64'd1);
        check("p1_idle_state", 64'(state_dbg1), 64'(IDLE));

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test expected finish within 1 ms");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mat_serializer.md
Name: mat_serializer

Overview:
Consumer end of the matrix stb/ack result interface. Accepts one packed M×N matrix of 32-bit words per handshake, as produced on mat_product's output_z/output_z_stb/output_z_ack. It then streams the elements out one word per stb/ack handshake, toward a UART/host readback path or another element-serial consumer. It also emits a last flag and row/column indices.

Parameters:
M, 2, number of matrix rows (≥1)
N, 2, number of matrix columns (≥1)
W, 32, element width in bits (IEEE-754 single)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
input_z  input  M*N*W  packed [M-1:0][N-1:0][W-1:0]; element (i,j) at bits [(i*N+j)*W +: W]
input_z_stb  input  1  producer: matrix valid, held until acknowledged
input_z_ack  output  1  block ready to take a matrix
output_elem  output  W  current element word
output_elem_stb  output  1  output_elem valid
output_elem_ack  input  1  downstream accepts current element
output_last  output  1  current element is the final one of the matrix
output_row  output  max(1,$clog2(M))  row index of current element
output_col  output  max(1,$clog2(N))  column index of current element

Behaviour:
- All outputs are registered. While rst=0, and asynchronously on assertion: input_z_ack=0, output_elem_stb=0, output_elem=0, output_last=0, output_row=0, output_col=0, state=IDLE, and the matrix buffer is cleared.
- A transfer occurs on a rising edge where stb=1 and ack=1. Both interfaces use this rule.
- State IDLE: input_z_ack=1 from the first edge after reset release. On an input transfer:
  - latch input_z into the buffer;
  - drop ack;
  - go to EMIT with index (0,0).
  - output_elem_stb=1 and output_elem=element(0,0) on the next edge, so latency is 1 cycle from accept to first element valid.
- State EMIT: input_z_ack=0, and input_z_stb is ignored (the producer holds its data).
  - output_elem, output_row, output_col and output_last stay stable until an output transfer.
  - On an output transfer that is not the last element: advance the index in row-major order (col+1; at col=N-1 wrap col to 0 and row+1). The next word is valid on the following edge, and stb stays 1, so one element is emitted per cycle when ack is held high.
  - output_last=1 exactly when (row,col)=(M-1,N-1).
  - On the output transfer of the last element: output_elem_stb=0, output_last=0, go to IDLE. input_z_ack=1 on that same edge, so the next matrix can be accepted one cycle later. Throughput is M*N+1 cycles per matrix.
- M=1,N=1: the single element has output_last=1. IDLE/EMIT alternate.
- Reset mid-EMIT: the stream aborts immediately. Remaining elements are discarded and no partial continuation occurs after release.
- output_elem_ack while output_elem_stb=0 is ignored.
- The index counters never exceed M-1/N-1.
- No arithmetic on data: words pass bit-exact.

Optional Feature:
Macro MAT_SER_COL_MAJOR_EN.
- Defined: emission order is column-major. Row advances first; at row=M-1, row wraps to 0 and col increments. output_last is still asserted at (M-1,N-1), and the indices report the true (row,col).
- Undefined: row-major order as above.
- Handshake timing is identical in both modes.

Decomposition:
- Shared package linalg_pkg holds the following, reused by mat_product and future linalg blocks:
  - localparam WORD_W=32;
  - the 2-state enum typedef ser_state_t {IDLE, EMIT};
  - an index-width helper function (max(1,$clog2(x))).
- No sub-module. The index counter and mux are inline; a separate module adds only port overhead.

Test Plan:
1. M=2,N=3, buffer [1,2,3;4,5,6] (3F800000,40000000,40400000,40800000,40A00000,40C00000), output_elem_ack tied 1 -> six consecutive cycles emit that word sequence with (row,col)=(0,0)..(1,2). output_last is high only on 40C00000. input_z_ack returns on the last-transfer edge.
2. Same matrix, output_elem_ack toggled 1,0,0,1,... -> each word held stable while ack=0, no word skipped or duplicated, total 6 transfers.
3. MAT_SER_COL_MAJOR_EN defined, same matrix -> order 3F800000,40800000,40000000,40A00000,40400000,40C00000. Indices (0,0),(1,0),(0,1),(1,1),(0,2),(1,2).
4. Two matrices back-to-back with input_z_stb held high, second = [7..12] (40E00000..41400000) -> second accepted exactly 1 cycle after first's last transfer. 12 words in order, no overlap.
5. rst driven 0 after third element of test 1 -> all outputs 0 asynchronously. After release input_z_ack=1, and a new matrix starts again at element (0,0).
6. M=1,N=1, input 41B00000 -> single element with output_last=1, then IDLE. Repeat 3 times with stable 2-cycle period.
